// File: rtl/pac_pkg.sv
// Shared Pac-Man control definitions: direction codes, direction-FSM states,
// and key-index decoding used by the direction and menu logic.
package pac_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned KEY_W = 4;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_R = 2'd0;
  localparam dir_t DIR_D = 2'd1;
  localparam dir_t DIR_L = 2'd2;
  localparam dir_t DIR_U = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_Q_PEND = 2'd1,
    ST_Q_CUR  = 2'd2,
    ST_STEP   = 2'd3
  } dir_state_e;

  // Key bit index to direction code: [0]=right [1]=down [2]=left [3]=up
  function automatic dir_t key_idx_to_dir(input logic [1:0] idx);
    dir_t d;
    case (idx)
      2'd0:    d = DIR_R;
      2'd1:    d = DIR_D;
      2'd2:    d = DIR_L;
      default: d = DIR_U;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pac_key_prio.sv
// Lowest-index-wins priority encoder turning key pulses into a direction.
// Purely combinational; also reused by the menu logic.
module pac_key_prio
  import pac_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  output logic             hit_c_o,
  output logic [DIR_W-1:0] dir_c_o
);

  logic [1:0] idx;

  always_comb begin
    idx = 2'd0;
    if (key_i[0])      idx = 2'd0;
    else if (key_i[1]) idx = 2'd1;
    else if (key_i[2]) idx = 2'd2;
    else if (key_i[3]) idx = 2'd3;
    hit_c_o = |key_i;
    dir_c_o = key_idx_to_dir(idx);
  end

endmodule

// File: rtl/pac_dir_ctrl.sv
// Pac-Man direction controller: buffers the latest turn request, checks it
// against the maze wall map on each movement tick and emits step pulses.
module pac_dir_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned PEND_TTL    = 8,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TTL_W       = 4,
  parameter int unsigned TO_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_pulse,
  input  logic             move_tick,
  output logic             query_req,
  output logic [DIR_W-1:0] query_dir,
  input  logic             query_ack,
  input  logic             query_blocked,
  output logic [DIR_W-1:0] cur_dir,
  output logic             moving,
  output logic             step_pulse,
  output logic             pend_valid,
  output logic [DIR_W-1:0] pend_dir,
  output logic             tick_overrun
);

  dir_state_e       state_q, state_d;
  logic [DIR_W-1:0] cur_dir_q, cur_dir_d;
  logic             moving_q, moving_d;
  logic             step_q, step_d;
  logic             qreq_q, qreq_d;
  logic [DIR_W-1:0] qdir_q, qdir_d;
  logic             pend_valid_q, pend_valid_d;
  logic [DIR_W-1:0] pend_dir_q, pend_dir_d;
  logic             pend_new_q, pend_new_d;
  logic [DIR_W-1:0] snap_dir_q, snap_dir_d;
  logic [TTL_W-1:0] age_q, age_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             overrun_q, overrun_d;

  logic             key_hit;
  logic [DIR_W-1:0] key_dir;
  logic             in_query;
  logic             ack_taken;
  logic             timeout;

  pac_key_prio u_key_prio (
    .key_i   (key_pulse),
    .hit_c_o (key_hit),
    .dir_c_o (key_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_R;
      moving_q     <= 1'b0;
      step_q       <= 1'b0;
      qreq_q       <= 1'b0;
      qdir_q       <= DIR_R;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_R;
      pend_new_q   <= 1'b0;
      snap_dir_q   <= DIR_R;
      age_q        <= '0;
      to_q         <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      moving_q     <= moving_d;
      step_q       <= step_d;
      qreq_q       <= qreq_d;
      qdir_q       <= qdir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      pend_new_q   <= pend_new_d;
      snap_dir_q   <= snap_dir_d;
      age_q        <= age_d;
      to_q         <= to_d;
      overrun_q    <= overrun_d;
    end
  end

  // Acks only count while a query is actually on the bus
  assign in_query  = (state_q == ST_Q_PEND) || (state_q == ST_Q_CUR);
  assign ack_taken = in_query && qreq_q && query_ack;
  assign timeout   = in_query && qreq_q && !query_ack &&
                     (to_q == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    moving_d     = moving_q;
    qdir_d       = qdir_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    pend_new_d   = pend_new_q;
    snap_dir_d   = snap_dir_q;
    age_d        = age_q;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (move_tick) begin
          if (pend_valid_q) begin
            snap_dir_d = pend_dir_q;
            pend_new_d = 1'b0;
            state_d    = ST_Q_PEND;
          end else if (moving_q) begin
            state_d = ST_Q_CUR;
          end
        end
      end
      ST_Q_PEND: begin
        if (ack_taken && !query_blocked) begin
          cur_dir_d = snap_dir_q;
          moving_d  = 1'b1;
          if (!pend_new_q) pend_valid_d = 1'b0;
          state_d = ST_STEP;
        end else if (ack_taken || timeout) begin
          state_d = moving_q ? ST_Q_CUR : ST_IDLE;
        end
      end
      ST_Q_CUR: begin
        if (ack_taken && !query_blocked) begin
          state_d = ST_STEP;
        end else if (ack_taken || timeout) begin
          moving_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (move_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    if (move_tick && pend_valid_q && !key_hit) begin
      age_d = age_q + TTL_W'(1);
      if (age_d == TTL_W'(PEND_TTL)) pend_valid_d = 1'b0;
    end

    // A fresh key always wins over expiry and over the ack-time clear
    if (key_hit) begin
      pend_dir_d   = key_dir;
      pend_valid_d = 1'b1;
      pend_new_d   = 1'b1;
      age_d        = '0;
    end

    if (state_d == ST_Q_PEND)     qdir_d = snap_dir_d;
    else if (state_d == ST_Q_CUR) qdir_d = cur_dir_d;
  end

  // Request drops for a cycle after every ack or timeout, so each query is a fresh rising edge
  always_comb begin
    qreq_d = ((state_d == ST_Q_PEND) || (state_d == ST_Q_CUR)) && !ack_taken && !timeout;
    step_d = (state_d == ST_STEP);
    if (state_d != state_q) to_d = '0;
    else if (qreq_q)        to_d = to_q + TO_W'(1);
    else                    to_d = to_q;
  end

  assign query_req    = qreq_q;
  assign query_dir    = qdir_q;
  assign cur_dir      = cur_dir_q;
  assign moving       = moving_q;
  assign step_pulse   = step_q;
  assign pend_valid   = pend_valid_q;
  assign pend_dir     = pend_dir_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Scoreboard bench for pac_dir_ctrl: stimulus queues expected query/step
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_pac_dir_ctrl;
  import pac_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_pulse = 4'b0;
  logic       move_tick = 1'b0;
  logic       query_req;
  logic [1:0] query_dir;
  logic       query_ack = 1'b0;
  logic       query_blocked = 1'b0;
  logic [1:0] cur_dir;
  logic       moving;
  logic       step_pulse;
  logic       pend_valid;
  logic [1:0] pend_dir;
  logic       tick_overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  pac_dir_ctrl #(
    .PEND_TTL(8), .ACK_TIMEOUT(16), .TTL_W(4), .TO_W(5)
  ) dut (
    .clk(clk), .reset(reset), .key_pulse(key_pulse), .move_tick(move_tick),
    .query_req(query_req), .query_dir(query_dir), .query_ack(query_ack),
    .query_blocked(query_blocked), .cur_dir(cur_dir), .moving(moving),
    .step_pulse(step_pulse), .pend_valid(pend_valid), .pend_dir(pend_dir),
    .tick_overrun(tick_overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event encoding: {1'b0,dir} = new query, {1'b1,dir} = step pulse in cur_dir
  task automatic pop_check(input string name, input logic [2:0] got);
    logic [2:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event got %0d expected none (t=%0t)", name, got, $time);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, e, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (query_req && !prev_req) pop_check("query_event", {1'b0, query_dir});
      if (step_pulse)             pop_check("step_event", {1'b1, cur_dir});
    end
    prev_req = query_req;
  end

  task automatic push_q(input logic [1:0] d); exp_q.push_back({1'b0, d}); endtask
  task automatic push_s(input logic [1:0] d); exp_q.push_back({1'b1, d}); endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_key(input logic [3:0] k);
    @(negedge clk); key_pulse = k;
    @(negedge clk); key_pulse = 4'b0;
  endtask

  task automatic tick();
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
  endtask

  task automatic answer(input logic blocked);
    int n = 0;
    while (!query_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("query_req_seen", int'(query_req), 1);
    query_ack = 1'b1;
    query_blocked = blocked;
    @(negedge clk);
    query_ack = 1'b0;
    query_blocked = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cur_dir"},    int'(cur_dir), 0);
    check({tag, "_moving"},     int'(moving), 0);
    check({tag, "_step"},       int'(step_pulse), 0);
    check({tag, "_query_req"},  int'(query_req), 0);
    check({tag, "_query_dir"},  int'(query_dir), 0);
    check({tag, "_pend_valid"}, int'(pend_valid), 0);
    check({tag, "_pend_dir"},   int'(pend_dir), 0);
    check({tag, "_overrun"},    int'(tick_overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    idle(2);

    // 1: first right press, free path
    pulse_key(4'b0001);
    check("t1_pend_valid", int'(pend_valid), 1);
    check("t1_pend_dir", int'(pend_dir), int'(DIR_R));
    push_q(DIR_R); push_s(DIR_R);
    tick(); answer(1'b0); idle(3);
    check("t1_cur_dir", int'(cur_dir), int'(DIR_R));
    check("t1_moving", int'(moving), 1);
    check("t1_pend_cleared", int'(pend_valid), 0);

    // 2: up blocked, keep going right; pending up expires after 8 ticks of age
    pulse_key(4'b1000);
    push_q(DIR_U); push_q(DIR_R); push_s(DIR_R);
    tick(); answer(1'b1); answer(1'b0); idle(3);
    check("t2_cur_dir", int'(cur_dir), int'(DIR_R));
    check("t2_pend_valid", int'(pend_valid), 1);
    check("t2_pend_dir", int'(pend_dir), int'(DIR_U));
    for (int i = 1; i <= 8; i++) begin
      if (i <= 7) push_q(DIR_U);
      push_q(DIR_R); push_s(DIR_R);
      tick();
      if (i <= 7) answer(1'b1);
      answer(1'b0);
      idle(3);
      check($sformatf("t2_age_pend_valid_%0d", i), int'(pend_valid), (i < 7) ? 1 : 0);
    end

    // 3: down beats left
    pulse_key(4'b0110);
    check("t3_pend_valid", int'(pend_valid), 1);
    check("t3_pend_dir", int'(pend_dir), int'(DIR_D));

    // 4: new key during the pending query keeps the buffer alive
    push_q(DIR_D); push_s(DIR_D);
    tick(); pulse_key(4'b0100); answer(1'b0); idle(3);
    check("t4_cur_dir", int'(cur_dir), int'(DIR_D));
    check("t4_pend_valid", int'(pend_valid), 1);
    check("t4_pend_dir", int'(pend_dir), int'(DIR_L));
    push_q(DIR_L); push_s(DIR_L);
    tick(); answer(1'b0); idle(3);
    check("t4b_cur_dir", int'(cur_dir), int'(DIR_L));
    check("t4b_pend_valid", int'(pend_valid), 0);

    // 5: no ack at all -> timeout after 16 request cycles, stop moving
    push_q(DIR_L);
    tick();
    n = 0;
    while (query_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t5_req_cycles", n, 16);
    idle(2);
    check("t5_moving", int'(moving), 0);
    check("t5_query_req", int'(query_req), 0);
    check("t5_cur_dir", int'(cur_dir), int'(DIR_L));

    // 6: overrun during Q_CUR, then async reset mid-query
    pulse_key(4'b0001);
    push_q(DIR_R); push_s(DIR_R);
    tick(); answer(1'b0); idle(3);
    check("t6_moving", int'(moving), 1);
    push_q(DIR_R);
    tick();
    check("t6_overrun_before", int'(tick_overrun), 0);
    check("t6_in_query", int'(query_req), 1);
    tick();
    check("t6_overrun_after", int'(tick_overrun), 1);
    check("t6_still_query", int'(query_req), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    check("t6_post_overrun", int'(tick_overrun), 0);
    check("t6_post_query_req", int'(query_req), 0);
    check("t6_post_moving", int'(moving), 0);

    check("sb_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
